// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment display path and its
// binary-to-BCD front end.
package seg7_pkg;

  localparam int DIGITS = 8;
  localparam int BIN_W  = 27;

  localparam logic [31:0] BCD_MAX = 32'd99_999_999;

  // Nibble code the scan driver renders as an unlit digit.
  localparam logic [3:0] NIBBLE_BLANK = 4'hF;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } conv_state_e;

  // 10^n evaluated at elaboration time for the overflow threshold.
  function automatic longint unsigned pow10(input int n);
    longint unsigned acc;
    acc = 64'd1;
    for (int i = 0; i < n; i++) begin
      acc = acc * 64'd10;
    end
    return acc;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a nibble of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_add3 (
  input  logic [3:0] nibble,
  output logic [3:0] corrected
);

  // Conditional +3 on a single BCD digit.
  always_comb begin
    if (nibble >= 4'd5) begin
      corrected = nibble + 4'd3;
    end else begin
      corrected = nibble;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per cycle, BIN_W cycles per
// conversion, result held in registers that feed the seven-segment driver.
module bin2bcd_seq #(
  parameter int BIN_W  = seg7_pkg::BIN_W,
  parameter int DIGITS = seg7_pkg::DIGITS
) (
  input  logic                  CLK100MHZ,
  input  logic                  CPU_RESETN,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  import seg7_pkg::*;

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam longint unsigned BCD_LIMIT = pow10(DIGITS) - 64'd1;
  // When 2^BIN_W already fits below 10^DIGITS no input can overflow.
  localparam bit LIMIT_FITS = (BIN_W < 63) && (BCD_LIMIT < (64'd1 << BIN_W));

  conv_state_e          state_r;
  conv_state_e          state_nx_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [BIN_W-1:0]     shift_r;
  logic [BCD_W-1:0]     scratch_r;
  logic                 ovf_pend_r;
  logic                 busy_r;
  logic                 done_r;
  logic [BCD_W-1:0]     bcd_r;
  logic                 ovf_r;

  logic                 load_s;
  logic                 step_s;
  logic                 finish_s;
  logic                 ovf_chk_s;
  logic [BCD_W-1:0]     corr_s;
  logic [BCD_W-1:0]     shifted_s;
  logic                 unused_msb_s;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .nibble    (scratch_r[4*g +: 4]),
      .corrected (corr_s[4*g +: 4])
    );
  end

  // The top corrected bit is shifted out of the scratch and dropped.
  assign shifted_s    = {corr_s[BCD_W-2:0], shift_r[BIN_W-1]};
  assign unused_msb_s = corr_s[BCD_W-1];

  // Overflow threshold compare at BIN_W+1 bits.
  always_comb begin
    if (LIMIT_FITS) begin
      ovf_chk_s = ({1'b0, bin} > (BIN_W + 1)'(BCD_LIMIT));
    end else begin
      ovf_chk_s = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next state and datapath strobes.
  always_comb begin
    state_nx_s = state_r;
    load_s     = 1'b0;
    step_s     = 1'b0;
    finish_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          load_s     = 1'b1;
          state_nx_s = CONV;
        end else begin
          state_nx_s = IDLE;
        end
      end
      CONV: begin
        step_s = 1'b1;
        if (cnt_r == CNT_W'(1)) begin
          finish_s   = 1'b1;
          state_nx_s = IDLE;
        end else begin
          state_nx_s = CONV;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Shift register, scratch and step counter.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      shift_r    <= '0;
      scratch_r  <= '0;
      cnt_r      <= '0;
      ovf_pend_r <= 1'b0;
    end else if (load_s) begin
      shift_r    <= bin;
      scratch_r  <= '0;
      cnt_r      <= CNT_W'(BIN_W);
      ovf_pend_r <= ovf_chk_s;
    end else if (step_s) begin
      shift_r    <= {shift_r[BIN_W-2:0], 1'b0};
      scratch_r  <= shifted_s;
      cnt_r      <= cnt_r - CNT_W'(1);
    end else begin
      shift_r    <= shift_r;
      scratch_r  <= scratch_r;
      cnt_r      <= cnt_r;
    end
  end

  // Output registers; bcd/ovf change only on completion.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      bcd_r  <= '0;
      ovf_r  <= 1'b0;
    end else begin
      done_r <= finish_s;
      if (load_s) begin
        busy_r <= 1'b1;
      end else if (finish_s) begin
        busy_r <= 1'b0;
        bcd_r  <= ovf_pend_r ? {DIGITS{4'h9}} : shifted_s;
        ovf_r  <= ovf_pend_r;
      end else begin
        busy_r <= busy_r;
      end
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign bcd  = bcd_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed vector table, start-while-busy,
// back-to-back, mid-conversion reset and random values against a decimal model.
module tb_bin2bcd_seq;

  logic        CLK100MHZ;
  logic        CPU_RESETN;
  logic        start;
  logic [26:0] bin;
  logic        busy;
  logic        done;
  logic [31:0] bcd;
  logic        ovf;

  int n_cmp = 0;
  int n_bad = 0;

  bin2bcd_seq dut (
    .CLK100MHZ  (CLK100MHZ),
    .CPU_RESETN (CPU_RESETN),
    .start      (start),
    .bin        (bin),
    .busy       (busy),
    .done       (done),
    .bcd        (bcd),
    .ovf        (ovf)
  );

  initial CLK100MHZ = 1'b0;
  always #5 CLK100MHZ = ~CLK100MHZ;

  typedef struct {
    logic [26:0] bin;
    logic [31:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Decimal reference: digit-by-digit division, saturating above 8 digits.
  function automatic logic [31:0] ref_bcd(input longint unsigned v);
    logic [31:0] r;
    r = 32'h0;
    if (v > 64'd99_999_999) return {8{4'h9}};
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(v % 64'd10);
      v = v / 64'd10;
    end
    return r;
  endfunction

  // Drives start for the current negedge; returns at the negedge after E0.
  task automatic start_now(input logic [26:0] b);
    bin   = b;
    start = 1'b1;
    @(negedge CLK100MHZ);
    start = 1'b0;
    bin   = ~b;
  endtask

  task automatic wait_done(output int lat, output int busy_cyc);
    lat      = 0;
    busy_cyc = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cyc++;
      @(negedge CLK100MHZ);
      lat++;
    end
  endtask

  task automatic convert_check(input string name, input logic [26:0] b,
                               input logic [31:0] exp_bcd, input logic exp_ovf);
    int lat, bc;
    @(negedge CLK100MHZ);
    start_now(b);
    wait_done(lat, bc);
    chk({name, " latency"}, lat, 27);
    chk({name, " busy_cycles"}, bc, 27);
    chk({name, " bcd"}, bcd, exp_bcd);
    chk({name, " ovf"}, ovf, exp_ovf);
    chk({name, " busy_at_done"}, busy, 0);
    @(negedge CLK100MHZ);
    chk({name, " done_width"}, done, 0);
    chk({name, " bcd_hold"}, bcd, exp_bcd);
  endtask

  initial begin
    int lat, bc;
    logic seen;
    logic [26:0] r;

    vecs[0] = '{27'd0,           32'h00000000, 1'b0};
    vecs[1] = '{27'd12_345_678,  32'h12345678, 1'b0};
    vecs[2] = '{27'd99_999_999,  32'h99999999, 1'b0};
    vecs[3] = '{27'd100_000_000, 32'h99999999, 1'b1};
    vecs[4] = '{27'd134_217_727, 32'h99999999, 1'b1};
    vecs[5] = '{27'd5,           32'h00000005, 1'b0};

    CPU_RESETN = 1'b0;
    start      = 1'b0;
    bin        = 27'd0;
    repeat (3) @(negedge CLK100MHZ);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset bcd", bcd, 0);
    chk("reset ovf", ovf, 0);
    CPU_RESETN = 1'b1;
    @(negedge CLK100MHZ);

    for (int i = 0; i < 6; i++) begin
      convert_check($sformatf("vec%0d", i), vecs[i].bin, vecs[i].bcd, vecs[i].ovf);
    end

    // start with 42 at cycle 10 of a conversion of 7 is ignored
    @(negedge CLK100MHZ);
    start_now(27'd7);
    repeat (10) @(negedge CLK100MHZ);
    bin   = 27'd42;
    start = 1'b1;
    @(negedge CLK100MHZ);
    start = 1'b0;
    wait_done(lat, bc);
    chk("ignore latency", lat, 16);
    chk("ignore bcd", bcd, 32'h00000007);
    // accepted on the done cycle
    start_now(27'd42);
    wait_done(lat, bc);
    chk("b2b latency", lat, 27);
    chk("b2b bcd", bcd, 32'h00000042);
    chk("b2b ovf", ovf, 0);

    // reset mid-conversion
    @(negedge CLK100MHZ);
    start_now(27'd87_654_321);
    repeat (12) @(negedge CLK100MHZ);
    CPU_RESETN = 1'b0;
    #1;
    chk("midrst busy", busy, 0);
    chk("midrst bcd", bcd, 0);
    chk("midrst done", done, 0);
    chk("midrst ovf", ovf, 0);
    seen = 1'b0;
    repeat (4) begin
      @(negedge CLK100MHZ);
      if (done) seen = 1'b1;
    end
    CPU_RESETN = 1'b1;
    repeat (30) begin
      @(negedge CLK100MHZ);
      if (done || busy) seen = 1'b1;
    end
    chk("midrst no_done", seen, 0);
    convert_check("post_rst", 27'd87_654_321, 32'h87654321, 1'b0);

    // random values against the decimal model
    for (int i = 0; i < 30; i++) begin
      r = 27'($urandom);
      if (i % 5 == 0) r = 27'($urandom_range(99_999_999, 134_217_727));
      convert_check($sformatf("rnd%0d", i), r, ref_bcd(longint'(r)),
                    (longint'(r) > 64'd99_999_999));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
